// File: rtl/ldst_unit_pkg.sv
// ldst_unit_pkg
// Shared definitions for the load/store unit: access-size encodings, the
// controller state enum and the bit positions inside resp_err.
package ldst_unit_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ADDR = 2'b01,
    ST_MEM  = 2'b10,
    ST_DONE = 2'b11
  } ldst_state_e;

  localparam int ERR_MIS = 0;
  localparam int ERR_OOR = 1;

  // Access width in bytes: 1, 2, 4 or 8.
  function automatic logic [3:0] size_bytes(input logic [1:0] size);
    return 4'd1 << size;
  endfunction

endpackage

// File: rtl/ldst_unit_lane.sv
// ldst_lane
// Purely combinational lane steering for the load/store unit.
//   word        : memory word currently held for the access
//   src         : store source register value
//   lane        : byte offset of the access inside the word
//   size        : access size encoding
//   is_unsigned : zero-extend loads when 1, sign-extend when 0
//   merged      : word with the selected lanes replaced by src's low bytes
//   loaded      : selected lanes shifted down and extended to XLEN
//   stored      : src truncated to the access size (the data written)
module ldst_lane
  import ldst_unit_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0]              word,
  input  logic [XLEN-1:0]              src,
  input  logic [$clog2(XLEN/8)-1:0]    lane,
  input  logic [1:0]                   size,
  input  logic                         is_unsigned,
  output logic [XLEN-1:0]              merged,
  output logic [XLEN-1:0]              loaded,
  output logic [XLEN-1:0]              stored
);

  localparam int LB = $clog2(XLEN/8);

  logic [6:0]      nbits;
  logic [LB+2:0]   shamt;
  logic [XLEN-1:0] size_mask;
  logic [XLEN-1:0] msb_mask;
  logic [XLEN-1:0] raw;

  always_comb begin
    nbits     = {size_bytes(size), 3'b000};
    // A shift of XLEN or more yields zero, so a full-width access
    // produces an all-ones mask without a special case.
    size_mask = ~({XLEN{1'b1}} << nbits);
    msb_mask  = size_mask & ~(size_mask >> 1);
    shamt     = {lane, 3'b000};
    stored    = src & size_mask;
    merged    = (word & ~(size_mask << shamt)) | (stored << shamt);
    raw       = (word >> shamt) & size_mask;
    if (is_unsigned || ((raw & msb_mask) == '0)) begin
      loaded = raw;
    end else begin
      loaded = raw | ~size_mask;
    end
  end

endmodule

// File: rtl/ldst_unit.sv
// ldst_unit
// Single-outstanding load/store unit with an internal 32-entry register
// file and a word-addressed memory. One request is processed at a time;
// the completion pulse appears three clock edges after the accept edge.
//
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   req_valid / req_ready         : request handshake (ready only when idle)
//   req_store, req_size,
//   req_unsigned, rs1, rs2_rd,
//   offset                        : request fields, latched on accept
//   resp_valid                    : one-cycle completion pulse
//   resp_addr, resp_data,
//   resp_err                      : completion results (bit0 misaligned,
//                                   bit1 out of range)
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | ready; latch fields on req_valid
// ADDR    | form effective address, classify misaligned / out of range
// MEM     | capture addressed word into the holding register
// DONE    | commit store/load, drive response (visible next cycle)
module ldst_unit
  import ldst_unit_pkg::*;
#(
  parameter int XLEN      = 64,
  parameter int MEM_DEPTH = 1024,
  parameter int OFF_W     = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_store,
  input  logic [1:0]       req_size,
  input  logic             req_unsigned,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2_rd,
  input  logic [OFF_W-1:0] offset,
  output logic             resp_valid,
  output logic [XLEN-1:0]  resp_addr,
  output logic [XLEN-1:0]  resp_data,
  output logic [1:0]       resp_err
);

  localparam int LB = $clog2(XLEN/8);
  localparam int AW = $clog2(MEM_DEPTH);
  localparam logic [XLEN-1:0] DEPTH_X = XLEN'(MEM_DEPTH);

  ldst_state_e      state;
  logic             store_q;
  logic [1:0]       size_q;
  logic             uns_q;
  logic [4:0]       rs1_q;
  logic [4:0]       rd_q;
  logic [OFF_W-1:0] off_q;
  logic [XLEN-1:0]  addr_q;
  logic [1:0]       err_q;
  logic [XLEN-1:0]  hold_q;

  logic [XLEN-1:0]  rf_q  [32];
  // Each word is stored XORed with its own index, so storage that powers up
  // all-zero presents MEM[i] = i without any reset-time clearing.
  logic [XLEN-1:0]  mem_q [MEM_DEPTH];

  logic [XLEN-1:0]  base;
  logic [XLEN-1:0]  st_src;
  logic [XLEN-1:0]  ea;
  logic             mis;
  logic             oor;
  logic [3:0]       align_m;
  logic [AW-1:0]    widx;
  logic [XLEN-1:0]  mem_word;
  logic [XLEN-1:0]  merged;
  logic [XLEN-1:0]  loaded;
  logic [XLEN-1:0]  stored;
  logic             commit;

  assign base     = (rs1_q == 5'd0) ? '0 : rf_q[rs1_q];
  assign st_src   = (rd_q  == 5'd0) ? '0 : rf_q[rd_q];
  assign widx     = addr_q[LB +: AW];
  assign mem_word = mem_q[widx] ^ XLEN'(widx);
  assign commit   = (state == ST_DONE) && (err_q == 2'b00);

  always_comb begin
    ea      = base + {{(XLEN-OFF_W){off_q[OFF_W-1]}}, off_q};
    align_m = size_bytes(size_q) - 4'd1;
    mis     = ((ea[3:0] & align_m) != 4'd0) || ((XLEN == 32) && (size_q == SZ_D));
    oor     = (ea >> LB) >= DEPTH_X;
  end

  ldst_lane #(.XLEN(XLEN)) u_lane (
    .word        (hold_q),
    .src         (st_src),
    .lane        (addr_q[LB-1:0]),
    .size        (size_q),
    .is_unsigned (uns_q),
    .merged      (merged),
    .loaded      (loaded),
    .stored      (stored)
  );

  always_ff @(posedge clk) begin
    if (!rst && commit && store_q) begin
      mem_q[widx] <= merged ^ XLEN'(widx);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        rf_q[i] <= XLEN'(i);
      end
    end else if (commit && !store_q && (rd_q != 5'd0)) begin
      rf_q[rd_q] <= loaded;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_addr  <= '0;
      resp_data  <= '0;
      resp_err   <= 2'b00;
      store_q    <= 1'b0;
      size_q     <= SZ_B;
      uns_q      <= 1'b0;
      rs1_q      <= 5'd0;
      rd_q       <= 5'd0;
      off_q      <= '0;
      addr_q     <= '0;
      err_q      <= 2'b00;
      hold_q     <= '0;
    end else begin
      resp_valid <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            store_q   <= req_store;
            size_q    <= req_size;
            uns_q     <= req_unsigned;
            rs1_q     <= rs1;
            rd_q      <= rs2_rd;
            off_q     <= offset;
            req_ready <= 1'b0;
            state     <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          addr_q         <= ea;
          err_q[ERR_MIS] <= mis;
          err_q[ERR_OOR] <= oor;
          state          <= ST_MEM;
        end
        ST_MEM: begin
          if (err_q == 2'b00) begin
            hold_q <= mem_word;
          end
          state <= ST_DONE;
        end
        ST_DONE: begin
          resp_valid <= 1'b1;
          resp_addr  <= addr_q;
          resp_err   <= err_q;
          if (err_q != 2'b00) begin
            resp_data <= '0;
          end else if (store_q) begin
            resp_data <= stored;
          end else begin
            resp_data <= loaded;
          end
          req_ready <= 1'b1;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ldst_unit.sv
module tb_ldst_unit;
  import ldst_unit_pkg::*;

  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [4:0]  rs1;
  logic [4:0]  rs2_rd;
  logic [11:0] offset;
  logic        resp_valid;
  logic [63:0] resp_addr;
  logic [63:0] resp_data;
  logic [1:0]  resp_err;

  ldst_unit #(.XLEN(64), .MEM_DEPTH(DEPTH), .OFF_W(12)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_store    (req_store),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .rs1          (rs1),
    .rs2_rd       (rs2_rd),
    .offset       (offset),
    .resp_valid   (resp_valid),
    .resp_addr    (resp_addr),
    .resp_data    (resp_data),
    .resp_err     (resp_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural reference: byte-addressed view of a little-endian memory.
  longint unsigned m_rf  [32];
  longint unsigned m_mem [DEPTH];

  typedef struct {
    bit          st;
    logic [1:0]  sz;
    bit          uns;
    int          r1;
    int          r2;
    logic [11:0] off;
    logic [63:0] e_addr;
    logic [63:0] e_data;
    logic [1:0]  e_err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit st, logic [1:0] sz, bit uns, int r1, int r2,
                              logic [11:0] off, logic [63:0] ea, logic [63:0] ed,
                              logic [1:0] ee);
    vec_t v;
    v.st = st; v.sz = sz; v.uns = uns; v.r1 = r1; v.r2 = r2; v.off = off;
    v.e_addr = ea; v.e_data = ed; v.e_err = ee;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_rf[i] = longint'(i);
  endtask

  task automatic model_op(input bit st, input logic [1:0] sz, input bit uns,
                          input int r1, input int r2, input logic [11:0] off,
                          output logic [63:0] ea, output logic [63:0] data,
                          output logic [1:0] err);
    int n;
    longint unsigned a, w, sh, bv, mask;
    n    = 1 << sz;
    ea   = m_rf[r1] + {{52{off[11]}}, off};
    err  = 2'b00;
    err[0] = (ea % n) != 0;
    err[1] = (ea / 8) >= DEPTH;
    mask = (n == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * n)) - 1);
    data = 0;
    if (err != 2'b00) return;
    for (int b = 0; b < n; b++) begin
      a  = ea + b;
      w  = a / 8;
      sh = 8 * (a % 8);
      if (st) begin
        bv = (m_rf[r2] >> (8 * b)) & 64'hFF;
        m_mem[w] = (m_mem[w] & ~(64'hFF << sh)) | (bv << sh);
      end else begin
        bv = (m_mem[w] >> sh) & 64'hFF;
        data = data | (bv << (8 * b));
      end
    end
    if (st) begin
      data = m_rf[r2] & mask;
    end else begin
      if (!uns && data[8*n-1]) data = data | ~mask;
      if (r2 != 0) m_rf[r2] = data;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    for (int k = 0; k < 10 && !req_ready; k++) tick();
    chk("ready_wait", req_ready, 1'b1);
  endtask

  task automatic do_req(input bit st, input logic [1:0] sz, input bit uns,
                        input int r1, input int r2, input logic [11:0] off,
                        output logic [63:0] a, output logic [63:0] d,
                        output logic [1:0] e);
    int k;
    wait_ready();
    req_store    = st;
    req_size     = sz;
    req_unsigned = uns;
    rs1          = 5'(r1);
    rs2_rd       = 5'(r2);
    offset       = off;
    req_valid    = 1'b1;
    tick();
    req_valid = 1'b0;
    k = 0;
    do begin
      tick();
      k++;
    end while (!resp_valid && k < 6);
    chk("latency", 64'(k), 64'd3);
    a = resp_addr;
    d = resp_data;
    e = resp_err;
    tick();
    chk("pulse_width", resp_valid, 1'b0);
  endtask

  task automatic check_rf(input string nm);
    for (int i = 0; i < 32; i++) chk(nm, dut.rf_q[i], m_rf[i]);
  endtask

  logic [63:0] a, d, ma, md;
  logic [1:0]  e, me;
  int          k;

  initial begin
    for (int i = 0; i < DEPTH; i++) m_mem[i] = longint'(i);
    model_reset();

    // Directed table (hand-derived expectations, XLEN=64, MEM_DEPTH=1024).
    vecs.push_back(mk(1, SZ_D, 0,  8,  5, 12'h008, 64'd16, 64'd5, 2'b00));
    vecs.push_back(mk(0, SZ_D, 0, 16,  3, 12'hFF8, 64'd8,  64'd1, 2'b00));
    vecs.push_back(mk(1, SZ_B, 0,  8, 31, 12'h003, 64'd11, 64'h1F, 2'b00));
    vecs.push_back(mk(0, SZ_B, 0,  8,  4, 12'h003, 64'd11, 64'h1F, 2'b00));
    vecs.push_back(mk(0, SZ_D, 1,  8,  6, 12'h000, 64'd8,  64'h1F00_0001, 2'b00));
    vecs.push_back(mk(0, SZ_D, 0, 16,  7, 12'h000, 64'd16, 64'd5, 2'b00));
    vecs.push_back(mk(0, SZ_W, 0,  1,  9, 12'h000, 64'd1,  64'd0, 2'b01));
    vecs.push_back(mk(0, SZ_B, 1, 16, 10, 12'h0F0, 64'd256, 64'h20, 2'b00));
    vecs.push_back(mk(1, SZ_B, 0,  1, 10, 12'h000, 64'd1,  64'h20, 2'b00));
    vecs.push_back(mk(0, SZ_D, 0,  0, 11, 12'h000, 64'd0,  64'h2000, 2'b00));
    vecs.push_back(mk(0, SZ_D, 0, 11, 12, 12'h000, 64'd8192, 64'd0, 2'b10));
    vecs.push_back(mk(0, SZ_D, 0, 11, 13, 12'hFF8, 64'd8184, 64'd1023, 2'b00));
    vecs.push_back(mk(0, SZ_D, 0,  8,  0, 12'h000, 64'd8,  64'h1F00_0001, 2'b00));
    vecs.push_back(mk(0, SZ_D, 0,  0, 14, 12'hFF8, 64'hFFFF_FFFF_FFFF_FFF8, 64'd0, 2'b10));
    vecs.push_back(mk(0, SZ_B, 0, 16, 15, 12'h630, 64'd1600, 64'hFFFF_FFFF_FFFF_FFC8, 2'b00));
    vecs.push_back(mk(0, SZ_H, 1, 16, 17, 12'h630, 64'd1600, 64'hC8, 2'b00));
    vecs.push_back(mk(1, SZ_H, 0,  2, 15, 12'h000, 64'd2,  64'hFFC8, 2'b00));
    vecs.push_back(mk(0, SZ_W, 0,  0, 18, 12'h000, 64'd0,  64'hFFFF_FFFF_FFC8_2000, 2'b00));
    vecs.push_back(mk(1, SZ_D, 0,  1,  5, 12'h000, 64'd1,  64'd0, 2'b01));

    // Reset with a simultaneous request: reset must win.
    rst = 1'b1; req_valid = 1'b1; req_store = 1'b1; req_size = SZ_D;
    req_unsigned = 1'b0; rs1 = 5'd8; rs2_rd = 5'd5; offset = 12'h0;
    tick(); tick();
    rst = 1'b0; req_valid = 1'b0;
    chk("rst_ready", req_ready, 1'b1);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_resp_addr", resp_addr, 64'd0);
    chk("rst_resp_data", resp_data, 64'd0);
    chk("rst_resp_err", resp_err, 2'b00);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rst_no_resp", resp_valid, 1'b0);
    end
    check_rf("rst_rf");

    foreach (vecs[i]) begin
      do_req(vecs[i].st, vecs[i].sz, vecs[i].uns, vecs[i].r1, vecs[i].r2, vecs[i].off, a, d, e);
      model_op(vecs[i].st, vecs[i].sz, vecs[i].uns, vecs[i].r1, vecs[i].r2, vecs[i].off, ma, md, me);
      chk($sformatf("vec%0d_addr", i), a, vecs[i].e_addr);
      chk($sformatf("vec%0d_data", i), d, vecs[i].e_data);
      chk($sformatf("vec%0d_err", i), e, vecs[i].e_err);
    end
    check_rf("table_rf");

    // req_valid held through ADDR/MEM/DONE: ignored, nothing queued.
    wait_ready();
    req_store = 1'b0; req_size = SZ_D; req_unsigned = 1'b0;
    rs1 = 5'd8; rs2_rd = 5'd21; offset = 12'h0; req_valid = 1'b1;
    tick();
    req_store = 1'b1; rs1 = 5'd0; rs2_rd = 5'd31;
    for (int c = 0; c < 3; c++) begin
      chk("busy_ready", req_ready, 1'b0);
      chk("busy_resp", resp_valid, 1'b0);
      tick();
    end
    req_valid = 1'b0;
    model_op(0, SZ_D, 0, 8, 21, 12'h0, ma, md, me);
    chk("busy_done", resp_valid, 1'b1);
    chk("busy_data", resp_data, md);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("busy_no_queue", resp_valid, 1'b0);
    end
    do_req(0, SZ_D, 0, 0, 22, 12'h0, a, d, e);
    model_op(0, SZ_D, 0, 0, 22, 12'h0, ma, md, me);
    chk("busy_mem0", d, md);

    // Reset while a store sits in MEM: abandoned, no write, no response.
    wait_ready();
    req_store = 1'b1; req_size = SZ_D; rs1 = 5'd8; rs2_rd = 5'd5;
    offset = 12'h0; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    chk("midrst_ready", req_ready, 1'b1);
    chk("midrst_resp", resp_valid, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("midrst_no_resp", resp_valid, 1'b0);
    end
    check_rf("midrst_rf");
    do_req(0, SZ_D, 0, 8, 20, 12'h0, a, d, e);
    model_op(0, SZ_D, 0, 8, 20, 12'h0, ma, md, me);
    chk("midrst_mem1", d, md);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 300; i++) begin
      bit          st, uns;
      logic [1:0]  sz;
      int          r1, r2;
      logic [11:0] off;
      st  = ($urandom_range(0, 2) == 0);
      sz  = 2'($urandom_range(0, 3));
      uns = 1'($urandom_range(0, 1));
      r1  = $urandom_range(0, 31);
      r2  = $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1)
        off = 12'($urandom_range(0, 1023)) & ~(12'(size_bytes(sz)) - 12'd1);
      else
        off = 12'($urandom_range(0, 4095));
      do_req(st, sz, uns, r1, r2, off, a, d, e);
      model_op(st, sz, uns, r1, r2, off, ma, md, me);
      chk("rnd_addr", a, ma);
      chk("rnd_data", d, md);
      chk("rnd_err", e, me);
    end
    check_rf("rnd_rf");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
